coord_uart_tx: RTL and testbench

COORD_UART_TX -- requirements
Module: coord_uart_tx

---
 rtl/coord_uart_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 71 +++++++
 rtl/coord_uart_tx.sv | 74 +++++++
 tb/tb_coord_uart_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/coord_uart_pkg.sv
// coord_uart_pkg: shared constants, FSM state type and packet helpers for the coordinate UART link
package coord_uart_pkg;
   localparam logic [7:0] HDR0 = 8'hAA;
   localparam logic [7:0] HDR1 = 8'h55;
   localparam int PKT_LEN = 7;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction
   // packet byte idx for latched centroid; last byte is the XOR of bytes 2..5
   function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [11:0] x, input logic [11:0] y);
      logic [7:0] chk;
      chk = {4'h0, x[11:8] ^ y[11:8]} ^ x[7:0] ^ y[7:0];
      case (idx)
         3'd0: pkt_byte = HDR0;
         3'd1: pkt_byte = HDR1;
         3'd2: pkt_byte = {4'h0, x[11:8]};
         3'd3: pkt_byte = x[7:0];
         3'd4: pkt_byte = {4'h0, y[11:8]};
         3'd5: pkt_byte = y[7:0];
         default: pkt_byte = chk;
      endcase
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer, LSB first, DIV clocks per bit
//   hdmi_clk1x_i  clock
//   rst_n_i       async active-low reset
//   start         accept data_in (only honoured while ready)
//   data_in       byte to send
//   ready         idle, or in the final clock of a stop bit (allows back-to-back bytes)
//   tx            registered serial output, idle high
module uart_tx_byte
   import coord_uart_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic       hdmi_clk1x_i,
   input  logic       rst_n_i,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       ready,
   output logic       tx
);
   localparam int CW = $clog2(DIV + 1);
   tx_state_t      state;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic           last;
   assign last  = cnt == CW'(DIV - 1);
   assign ready = state == IDLE || (state == STOP && last);
   always_ff @(posedge hdmi_clk1x_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (start) begin
               state <= START;
               shreg <= data_in;
               tx    <= 1'b0;
            end
            START: if (last) begin
               state   <= DATA;
               tx      <= shreg[0];
               shreg   <= shreg >> 1;
               bit_idx <= '0;
            end
            DATA: if (last) begin
               if (bit_idx == 3'd7) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
            STOP: if (last) begin
               if (start) begin
                  state <= START;
                  shreg <= data_in;
                  tx    <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: rtl/coord_uart_tx.sv
// coord_uart_tx: sends the latched centroid as a 7-byte UART packet on each lcd_vs rising edge
//   hdmi_clk1x_i  pixel clock
//   rst_n_i       async active-low reset
//   lcd_vs        frame sync; rising edge triggers a packet
//   x_in, y_in    12-bit centroid, latched at the trigger
//   uart_tx       serial line, 8N1, idle high
//   busy          packet in flight
//   frame_sent    pulse as the last stop bit completes
//   frame_drop    pulse when a trigger arrives while busy
module coord_uart_tx
   import coord_uart_pkg::*;
#(
   parameter int CLK_FREQ = 74_250_000,
   parameter int BAUD     = 115_200
) (
   input  logic        hdmi_clk1x_i,
   input  logic        rst_n_i,
   input  logic        lcd_vs,
   input  logic [11:0] x_in,
   input  logic [11:0] y_in,
   output logic        uart_tx,
   output logic        busy,
   output logic        frame_sent,
   output logic        frame_drop
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);
   logic        vs_d, armed, trig, byte_ready, byte_start;
   logic [2:0]  idx;
   logic [11:0] x_lat, y_lat;
   logic [7:0]  byte_data;
   // armed requires lcd_vs to be seen low after reset, so a level held high through release is not an edge
   assign trig       = lcd_vs & ~vs_d & armed;
   assign byte_start = busy ? (byte_ready && idx != LAST_IDX) : trig;
   assign byte_data  = pkt_byte(busy ? idx + 3'd1 : 3'd0, x_lat, y_lat);
   always_ff @(posedge hdmi_clk1x_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vs_d       <= 1'b0;
         armed      <= 1'b0;
         busy       <= 1'b0;
         idx        <= '0;
         x_lat      <= '0;
         y_lat      <= '0;
         frame_sent <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         vs_d       <= lcd_vs;
         armed      <= armed | ~lcd_vs;
         frame_sent <= 1'b0;
         frame_drop <= trig & busy;
         if (!busy && trig) begin
            busy  <= 1'b1;
            idx   <= '0;
            x_lat <= x_in;
            y_lat <= y_in;
         end else if (busy && byte_ready) begin
            if (idx == LAST_IDX) begin
               busy       <= 1'b0;
               frame_sent <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end
   uart_tx_byte #(.DIV(DIV)) u_byte (
      .hdmi_clk1x_i (hdmi_clk1x_i),
      .rst_n_i      (rst_n_i),
      .start        (byte_start),
      .data_in      (byte_data),
      .ready        (byte_ready),
      .tx           (uart_tx)
   );
endmodule

// File: tb/tb_coord_uart_tx.sv
// tb_coord_uart_tx: scoreboard bench decoding the UART line against expected packet bytes
module tb_coord_uart_tx;
   logic        clk, rst_n, lcd_vs;
   logic [11:0] x_in, y_in;
   logic        uart_tx, busy, frame_sent, frame_drop;
   logic [7:0]  q[$];
   int          checks = 0;
   int          errors = 0;
   logic [9:0]  fa, fb;
   logic [7:0]  e;
   bit          ab;
   coord_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
      .hdmi_clk1x_i (clk),
      .rst_n_i      (rst_n),
      .lcd_vs       (lcd_vs),
      .x_in         (x_in),
      .y_in         (y_in),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .frame_sent   (frame_sent),
      .frame_drop   (frame_drop)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic push_pkt(input logic [11:0] x, input logic [11:0] y);
      logic [7:0] b[6];
      b = '{8'hAA, 8'h55, {4'h0, x[11:8]}, x[7:0], {4'h0, y[11:8]}, y[7:0]};
      foreach (b[i]) q.push_back(b[i]);
      q.push_back(b[2] ^ b[3] ^ b[4] ^ b[5]);
   endtask
   // decode every frame: sample each bit just after it starts and just before it ends
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && uart_tx === 1'b0) begin
            ab = 1'b0;
            for (int k = 0; k < 10; k++) begin
               repeat (k == 0 ? 1 : 2) @(negedge clk);
               fa[k] = uart_tx;
               ab |= !rst_n;
               repeat (8) @(negedge clk);
               fb[k] = uart_tx;
               ab |= !rst_n;
            end
            if (!ab) begin
               if (q.size() == 0) begin
                  check("unexpected_byte", {22'd0, fa}, 32'd0);
               end else begin
                  e = q.pop_front();
                  check("frame_early", {22'd0, fa}, {22'd0, 1'b1, e, 1'b0});
                  check("frame_late", {22'd0, fb}, {22'd0, 1'b1, e, 1'b0});
               end
            end
         end
      end
   end
   task automatic run_pkt(input logic [11:0] x, input logic [11:0] y, input int drop_at,
                          input int rst_at, input bit xchg, input int exp_drops);
      int n, drops;
      bit rstd;
      n = 0;
      drops = 0;
      rstd = 1'b0;
      @(negedge clk);
      check("idle_tx", uart_tx, 1);
      x_in = x;
      y_in = y;
      push_pkt(x, y);
      lcd_vs = 1'b1;
      @(negedge clk);
      check("start_tx", uart_tx, 0);
      check("start_busy", busy, 1);
      lcd_vs = 1'b0;
      if (xchg) x_in = 12'hFFF;
      while (!frame_sent && n < 1000 && !rstd) begin
         @(negedge clk);
         n++;
         if (frame_drop) drops++;
         if (n == drop_at) lcd_vs = 1'b1;
         if (n == drop_at + 1) lcd_vs = 1'b0;
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_tx", uart_tx, 1);
            check("rst_busy", busy, 0);
            q.delete();
            repeat (20) @(negedge clk);
            rst_n = 1'b1;
            rstd = 1'b1;
         end
      end
      if (!rstd) begin
         check("pkt_len", n, 700);
         check("busy_end", busy, 0);
         check("drops", drops, exp_drops);
         @(negedge clk);
         check("sent_pulse", frame_sent, 0);
         check("q_empty", q.size(), 0);
      end
      repeat (150) @(negedge clk);
   endtask
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int bad;
      rst_n = 1'b0;
      lcd_vs = 1'b0;
      x_in = '0;
      y_in = '0;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_busy0", busy, 0);
      check("rst_sent", frame_sent, 0);
      check("rst_drop", frame_drop, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      run_pkt(12'h123, 12'h0A5, 0, 0, 1'b0, 0);
      run_pkt(12'h123, 12'h0A5, 300, 0, 1'b0, 1);
      run_pkt(12'h123, 12'h0A5, 0, 0, 1'b1, 0);
      run_pkt(12'h456, 12'h789, 0, 250, 1'b0, 0);
      run_pkt(12'h456, 12'h789, 0, 0, 1'b0, 0);
      rst_n = 1'b0;
      lcd_vs = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("held_high_no_tx", bad, 0);
      lcd_vs = 1'b0;
      repeat (3) @(negedge clk);
      run_pkt(12'hABC, 12'h321, 0, 0, 1'b0, 0);
      run_pkt(12'hFFF, 12'hFFF, 0, 0, 1'b0, 0);
      run_pkt(12'h3C7, 12'hA18, 699, 0, 1'b0, 1);
      check("final_q_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
